clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Multi-channel programmable clock divider, the parametrised successor to the single-channel fixed-ratio divider. Each of `NUM_CH` channels produces a registered 50%-duty divided clock plus a one-cycle rising-edge tick. Each channel has its own run-time half-period value and enable. Half-period updates are shadowed and applied only at a period boundary, so an output never emits a runt pulse. A global `sync` input restarts all channels in phase. It sits between the board clock and the LED, blink and sampling logic that previously each instantiated a fixed divider.

## Interface
- `NUM_CH`, 4: number of independent divider channels (1..16).
- `COUNT_WIDTH`, 24: width of the half-period value and per-channel counter.
- `DEFAULT_HALF`, 6000000-1: reset value of every channel's active and shadow half-period.

- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `en`  in  NUM_CH: per-channel enable.
- `cfg_we`  in  1: write strobe for the shadow half-period.
- `cfg_ch`  in  $clog2(NUM_CH) (min 1): target channel of the write.
- `cfg_half`  in  COUNT_WIDTH: new half-period value H; output period is 2*(H+1) clk cycles.
- `sync`  in  1: restart all channels in phase.
- `out`  out  NUM_CH: divided clocks, registered.
- `tick`  out  NUM_CH: one-cycle pulse in the cycle `out[i]` rises, registered.
- `cfg_pending`  out  NUM_CH: shadow value written but not yet applied.

## Operation
- Per-channel state: active half-period A, shadow S, pending flag P, counter C, output O.
- Reset (rst=0 at an edge) sets:
  - A = S = DEFAULT_HALF.
  - P = 0, C = 0, O = 0, tick = 0, for all channels.
- Config write: `cfg_we`=1 with `cfg_ch`<NUM_CH sets S=cfg_half and P=1 for that channel. A second write before the boundary overwrites S. Writes with `cfg_ch`>=NUM_CH are ignored.
- Priority per channel, highest first: reset, `sync`, `en`=0, counting.
- `sync`=1 affects all channels:
  - C=0, O=0, tick=0.
  - If P, or if a write to that channel occurs in the same cycle, A loads the newest value (write data bypasses S) and P=0.
- `en[i]`=0:
  - C=0, O=0, tick=0.
  - Any pending S loads into A immediately and P=0. Writes while disabled therefore never stay pending.
- `en[i]`=1:
  - If C != A: C=C+1 and tick=0.
  - If C == A: C=0 and O is inverted.
    - When O goes 0 to 1, tick=1.
    - When O goes 0 to 1 and P=1, A=S and P=0. A write in that same cycle stays pending.
- The boundary is the rising edge of `out`, so the new value governs the whole next period.
- H=0 is legal: `out` toggles every cycle (clk/2) and tick is high every other cycle.
- Channels are fully independent apart from the shared config bus and `sync`.
- `cfg_pending[i]` = P.

## Timing
- From reset release, or `en` rising, or `sync` deassertion, with A=H:
  - First `out` rise after H+1 counting edges; `tick` is high in that same cycle.
  - Fall after a further H+1 edges. Period 2*(H+1), duty exactly 50%.
- Config latency:
  - Write to P=1: one edge.
  - S takes effect on the next `out` rise. The first full period at the new value starts with that rise.
- `out`, `tick` and `cfg_pending` are flop outputs with no combinational path from inputs.
- Reset mid-period drives `out` low on the reset edge, which may truncate a high phase; this is accepted.
- No runt pulse may result from config writes at any cycle offset.
- Counter never exceeds A.

## Test plan
- Reset, NUM_CH=2, DEFAULT_HALF=3, en=2'b11 -> out[0] and out[1] rise on edge 4 with tick, fall on edge 8, period 8 cycles, identical phase.
- Channel 0 running H=3. Write cfg_half=1 mid high-phase -> cfg_pending[0]=1. Remaining high phase still 4 cycles, following low phase still 4 cycles. From the next rise the period is 4 and pending clears on that edge.
- Channel 1 disabled. Write cfg_ch=1, cfg_half=0, then enable -> cfg_pending[1] never high. out[1] rises on the 1st enabled edge and toggles every cycle; tick[1] is high every 2nd cycle.
- Channels at H=2 and H=5 running out of phase. Pulse sync with a simultaneous write cfg_ch=0, cfg_half=4 -> both outputs low. Channel 0 rises 5 edges later with H=4, channel 1 rises 6 edges later with H=5.
- cfg_ch=NUM_CH write with cfg_half=7 -> no cfg_pending change; all periods unchanged.
- Assert rst=0 mid high-phase, hold 2 cycles, release -> all out/tick/cfg_pending=0 from the reset edge. Period returns to 2*DEFAULT_HALF+2 and earlier writes are discarded.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel emits a registered 50%-duty
// clock and a rising-edge tick, with half-period updates taking effect only on a rising edge.
module clock_divider_multi #(
  parameter int NUM_CH       = 4,
  parameter int COUNT_WIDTH  = 24,
  parameter int DEFAULT_HALF = 6000000 - 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CH-1:0]                        en,
  input  logic                                     cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [COUNT_WIDTH-1:0]                   cfg_half,
  input  logic                                     sync,
  output logic [NUM_CH-1:0]                        out,
  output logic [NUM_CH-1:0]                        tick,
  output logic [NUM_CH-1:0]                        cfg_pending
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [COUNT_WIDTH-1:0] DEF_HALF = COUNT_WIDTH'(DEFAULT_HALF);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                   hit;
    logic [COUNT_WIDTH-1:0] act_half_p0;
    logic [COUNT_WIDTH-1:0] shd_half_p0;
    logic [COUNT_WIDTH-1:0] cnt_p0;
    logic                   pend_p0;
    logic                   out_p0;
    logic                   tick_p0;

    // Out-of-range channel numbers can never equal a valid index, so they are dropped here.
    assign hit = cfg_we && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (!rst) begin
        act_half_p0 <= DEF_HALF;
        shd_half_p0 <= DEF_HALF;
        pend_p0     <= 1'b0;
        cnt_p0      <= '0;
        out_p0      <= 1'b0;
        tick_p0     <= 1'b0;
      end else if (sync || !en[i]) begin
        // Idle or restarting: a pending or coincident write is committed straight into A.
        cnt_p0  <= '0;
        out_p0  <= 1'b0;
        tick_p0 <= 1'b0;
        pend_p0 <= 1'b0;
        if (hit) begin
          act_half_p0 <= cfg_half;
          shd_half_p0 <= cfg_half;
        end else if (pend_p0) begin
          act_half_p0 <= shd_half_p0;
        end
      end else begin
        if (cnt_p0 != act_half_p0) begin
          cnt_p0  <= cnt_p0 + COUNT_WIDTH'(1);
          tick_p0 <= 1'b0;
        end else begin
          cnt_p0  <= '0;
          out_p0  <= ~out_p0;
          tick_p0 <= ~out_p0;
          if (!out_p0 && pend_p0) begin
            act_half_p0 <= shd_half_p0;
            pend_p0     <= 1'b0;
          end
        end
        // A write landing on the boundary edge overrides the clear above and stays pending.
        if (hit) begin
          shd_half_p0 <= cfg_half;
          pend_p0     <= 1'b1;
        end
      end
    end

    assign out[i]         = out_p0;
    assign tick[i]        = tick_p0;
    assign cfg_pending[i] = pend_p0;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: three channels, 8-bit counters, default half-period 3.
module tb_clock_divider_multi;

  localparam int NUM_CH = 3;
  localparam int CW     = 8;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CW-1:0]     cfg_half;
  logic              sync;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  int vectors;
  int miscompares;

  clock_divider_multi #(
    .NUM_CH(NUM_CH),
    .COUNT_WIDTH(CW),
    .DEFAULT_HALF(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
    .sync(sync),
    .out(out),
    .tick(tick),
    .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then both enabled channels run at H=3: rise on edge 4, fall on edge 8, in phase.
  task automatic test_reset();
    logic [1:0] eo, et;
    rst = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0; sync = 1'b0;
    step();
    step();
    vectors++;
    if ({out, tick, cfg_pending} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_state: out=%b tick=%b pend=%b expected all zero", out, tick, cfg_pending);
    end
    rst = 1'b1;
    en  = 3'b011;
    for (int k = 1; k <= 16; k++) begin
      step();
      eo = ((k % 8) >= 4) ? 2'b11 : 2'b00;
      et = ((k % 8) == 4) ? 2'b11 : 2'b00;
      vectors++;
      if (out[1:0] !== eo || tick[1:0] !== et) begin
        miscompares++;
        $display("FAIL reset_period k=%0d: out=%b tick=%b expected out=%b tick=%b", k, out[1:0], tick[1:0], eo, et);
      end
    end
  endtask

  // Channel 0 at H=3 gets H=1 mid high-phase; current period finishes untouched.
  task automatic test_cfg_midhigh();
    logic [2:0] eo, et, ep;
    for (int k = 17; k <= 21; k++) step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd1;
    for (int k = 22; k <= 37; k++) begin
      step();
      cfg_we = 1'b0;
      eo = '0; et = '0; ep = '0;
      if (k < 24)      eo[0] = 1'b1;
      else if (k >= 28) eo[0] = ((k - 28) % 4) < 2;
      et[0] = (k >= 28) && (((k - 28) % 4) == 0);
      ep[0] = (k < 28);
      eo[1] = (k % 8) >= 4;
      et[1] = (k % 8) == 4;
      vectors++;
      if (out !== eo || tick !== et || cfg_pending !== ep) begin
        miscompares++;
        $display("FAIL cfg_midhigh k=%0d: out=%b tick=%b pend=%b expected out=%b tick=%b pend=%b",
                 k, out, tick, cfg_pending, eo, et, ep);
      end
    end
  endtask

  // Write H=0 to disabled channel 1, then enable: clk/2 output, never pending.
  task automatic test_disabled_write();
    en = 3'b001;
    step();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd0;
    step();
    cfg_we = 1'b0;
    vectors++;
    if (cfg_pending[1] !== 1'b0 || out[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL disabled_write: pend1=%b out1=%b expected 0 0", cfg_pending[1], out[1]);
    end
    en = 3'b011;
    for (int j = 1; j <= 8; j++) begin
      step();
      vectors++;
      if (out[1] !== j[0] || tick[1] !== j[0] || cfg_pending[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL h0_run j=%0d: out1=%b tick1=%b pend1=%b expected %b %b 0",
                 j, out[1], tick[1], cfg_pending[1], j[0], j[0]);
      end
    end
  endtask

  // Channels at H=2 and H=5 out of phase; sync with a coincident write of H=4 to channel 0.
  task automatic test_sync();
    logic [2:0] eo, et;
    en = 3'b000;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2;
    step();
    cfg_ch = 2'd1; cfg_half = 8'd5;
    step();
    cfg_we = 1'b0;
    vectors++;
    if (cfg_pending !== 3'b000) begin
      miscompares++;
      $display("FAIL sync_setup: pend=%b expected 000", cfg_pending);
    end
    en = 3'b001;
    step();
    step();
    en = 3'b011;
    for (int j = 0; j < 7; j++) step();
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4;
    step();
    sync = 1'b0; cfg_we = 1'b0;
    vectors++;
    if (out !== 3'b000 || tick !== 3'b000 || cfg_pending !== 3'b000) begin
      miscompares++;
      $display("FAIL sync_edge: out=%b tick=%b pend=%b expected 000 000 000", out, tick, cfg_pending);
    end
    for (int j = 1; j <= 24; j++) begin
      step();
      eo = {1'b0, (j % 12) >= 6, (j % 10) >= 5};
      et = {1'b0, (j % 12) == 6, (j % 10) == 5};
      vectors++;
      if (out !== eo || tick !== et) begin
        miscompares++;
        $display("FAIL sync_run j=%0d: out=%b tick=%b expected out=%b tick=%b", j, out, tick, eo, et);
      end
    end
  endtask

  // Write to cfg_ch=3 (no such channel) must change nothing.
  task automatic test_bad_channel();
    logic [2:0] eo, et;
    sync = 1'b1;
    step();
    sync = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd7;
    for (int j = 1; j <= 24; j++) begin
      step();
      cfg_we = 1'b0;
      eo = {1'b0, (j % 12) >= 6, (j % 10) >= 5};
      et = {1'b0, (j % 12) == 6, (j % 10) == 5};
      vectors++;
      if (out !== eo || tick !== et || cfg_pending !== 3'b000) begin
        miscompares++;
        $display("FAIL bad_channel j=%0d: out=%b tick=%b pend=%b expected out=%b tick=%b pend=000",
                 j, out, tick, cfg_pending, eo, et);
      end
    end
  endtask

  // Pending write, then reset mid high-phase for 2 cycles: everything back to default H=3.
  task automatic test_reset_midhigh();
    logic [1:0] eo, et;
    step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd1;
    step();
    cfg_we = 1'b0;
    vectors++;
    if (cfg_pending !== 3'b001) begin
      miscompares++;
      $display("FAIL pre_reset_pend: pend=%b expected 001", cfg_pending);
    end
    step();
    vectors++;
    if (out[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_high: out0=%b expected 1", out[0]);
    end
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step();
      vectors++;
      if ({out, tick, cfg_pending} !== 9'b0) begin
        miscompares++;
        $display("FAIL midhigh_reset j=%0d: out=%b tick=%b pend=%b expected all zero", j, out, tick, cfg_pending);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      eo = ((k % 8) >= 4) ? 2'b11 : 2'b00;
      et = ((k % 8) == 4) ? 2'b11 : 2'b00;
      vectors++;
      if (out[1:0] !== eo || tick[1:0] !== et || cfg_pending !== 3'b000) begin
        miscompares++;
        $display("FAIL post_reset k=%0d: out=%b tick=%b pend=%b expected out=%b tick=%b pend=000",
                 k, out[1:0], tick[1:0], cfg_pending, eo, et);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_cfg_midhigh();
    test_disabled_write();
    test_sync();
    test_bad_channel();
    test_reset_midhigh();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
